// File: rtl/nn_pkg.sv
// Shared constants and the output-side state type for the switch front end
// of the neural-net input path.
package nn_pkg;

    localparam int NN_DATA_W         = 8;
    localparam int SYNC_STAGES_DEF   = 2;
    localparam int STABLE_CYCLES_DEF = 16;

    typedef enum logic [1:0] {
        OUT_EMPTY      = 2'd0,
        OUT_OFFER      = 2'd1,
        OUT_OFFER_PEND = 2'd2
    } out_state_e;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a bus of independent asynchronous bits.
// Every stage clears on reset; q is the last stage.
module sync_chain #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift the raw levels through the flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/sw_debounce_sampler.sv
// Debounces an 8-bit DIP switch and offers each newly settled value on a
// valid/ready source with one pending slot (last-wins on overflow).
module sw_debounce_sampler
    import nn_pkg::*;
#(
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NN_DATA_W-1:0] sw,
    output logic [NN_DATA_W-1:0] in_val,
    output logic                 in_valid,
    input  logic                 in_ready,
    output logic                 dropped
);

    localparam int             CNT_W   = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // A constant-one flag travels with the data so the filter ignores the
    // chain's reset contents until the first real sample reaches sw_sync.
    logic [NN_DATA_W:0]   sync_q;
    logic                 sync_valid;
    logic [NN_DATA_W-1:0] sw_sync;

    sync_chain #(
        .WIDTH (NN_DATA_W + 1),
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({1'b1, sw}),
        .q     (sync_q)
    );

    assign sync_valid = sync_q[NN_DATA_W];
    assign sw_sync    = sync_q[NN_DATA_W-1:0];

    logic [NN_DATA_W-1:0] candidate_r;
    logic [CNT_W-1:0]     counter_r;
    logic                 cand_valid_r;
    logic [NN_DATA_W-1:0] accepted_r;
    logic                 have_acc_r;
    logic                 stable_event_s;

    // The event is decoded from registers only, so it is glitch-free and
    // independent of in_ready.
    assign stable_event_s = cand_valid_r && (counter_r == CNT_MAX) &&
                            (!have_acc_r || (candidate_r != accepted_r));

    // Candidate/counter filter and last-accepted tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            candidate_r  <= '0;
            counter_r    <= '0;
            cand_valid_r <= 1'b0;
            accepted_r   <= '0;
            have_acc_r   <= 1'b0;
        end else begin
            if (sync_valid && (!cand_valid_r || (sw_sync != candidate_r))) begin
                candidate_r  <= sw_sync;
                counter_r    <= '0;
                cand_valid_r <= 1'b1;
            end else if (sync_valid && (counter_r != CNT_MAX)) begin
                counter_r <= counter_r + CNT_ONE;
            end
            if (stable_event_s) begin
                accepted_r <= candidate_r;
                have_acc_r <= 1'b1;
            end
        end
    end

    out_state_e           state_r, state_n;
    logic [NN_DATA_W-1:0] in_val_r, in_val_n;
    logic [NN_DATA_W-1:0] pend_r, pend_n;
    logic                 in_valid_r, in_valid_n;
    logic                 dropped_r, dropped_n;
    logic                 xfer_s;

    assign xfer_s = in_valid_r && in_ready;

    // Output state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= OUT_EMPTY;
            in_val_r   <= '0;
            pend_r     <= '0;
            in_valid_r <= 1'b0;
            dropped_r  <= 1'b0;
        end else begin
            state_r    <= state_n;
            in_val_r   <= in_val_n;
            pend_r     <= pend_n;
            in_valid_r <= in_valid_n;
            dropped_r  <= dropped_n;
        end
    end

    // Next-state logic of the one-slot source.
    always_comb begin
        state_n    = state_r;
        in_val_n   = in_val_r;
        pend_n     = pend_r;
        dropped_n  = 1'b0;
        in_valid_n = 1'b0;
        case (state_r)
            OUT_EMPTY: begin
                if (stable_event_s) begin
                    state_n  = OUT_OFFER;
                    in_val_n = candidate_r;
                end else begin
                    state_n = OUT_EMPTY;
                end
            end
            OUT_OFFER: begin
                if (stable_event_s && xfer_s) begin
                    in_val_n = candidate_r;
                end else if (stable_event_s) begin
                    state_n = OUT_OFFER_PEND;
                    pend_n  = candidate_r;
                end else if (xfer_s) begin
                    state_n = OUT_EMPTY;
                end else begin
                    state_n = OUT_OFFER;
                end
            end
            OUT_OFFER_PEND: begin
                if (stable_event_s && xfer_s) begin
                    in_val_n = pend_r;
                    pend_n   = candidate_r;
                end else if (stable_event_s) begin
                    pend_n    = candidate_r;
                    dropped_n = 1'b1;
                end else if (xfer_s) begin
                    state_n  = OUT_OFFER;
                    in_val_n = pend_r;
                end else begin
                    state_n = OUT_OFFER_PEND;
                end
            end
            default: begin
                state_n = OUT_EMPTY;
            end
        endcase
        in_valid_n = (state_n != OUT_EMPTY);
    end

    assign in_val   = in_val_r;
    assign in_valid = in_valid_r;
    assign dropped  = dropped_r;

endmodule
